// File: rtl/peri_readout_arbiter_pkg.sv
// Shared definitions for the column-peripheral readout arbiter.
//   N_COL     : number of column-peripheral FIFOs arbitrated
//   IDX_W     : column index width (2**IDX_W >= N_COL)
//   DATA_W    : width of one column FIFO word
//   OUT_W     : width of the tagged output word {col_idx, word}
//   BURST_DEF : default maximum words drained per grant
//   CNT_W_DEF : default width of the forwarded-word counter
//   arb_state_t : arbiter FSM state encoding
//   onehot()  : column index to one-hot grant vector
package peri_pkg;

    localparam int N_COL     = 8;
    localparam int IDX_W     = 3;
    localparam int DATA_W    = 28;
    localparam int OUT_W     = IDX_W + DATA_W;
    localparam int BURST_DEF = 4;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } arb_state_t;

    function automatic logic [N_COL-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_COL-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/peri_readout_arbiter_if.sv
// Bus between the column FIFOs / readout serializer and the arbiter.
//   empty           : per-column FIFO empty (bit i = column i)
//   fifo_data       : packed first-word-fall-through heads, column i at [i*DATA_W +: DATA_W]
//   shakehands_next : one-hot pop pulse toward the column FIFOs
//   out_data        : tagged word {col_idx, word} toward the serializer
//   out_valid       : out_data valid
//   out_ready       : serializer accepts on out_valid & out_ready
// master = arbiter side, slave = sources/serializer side.
interface peri_readout_arbiter_if;
    import peri_pkg::*;

    logic [N_COL-1:0]        empty;
    logic [N_COL*DATA_W-1:0] fifo_data;
    logic [N_COL-1:0]        shakehands_next;
    logic [OUT_W-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        input  empty, fifo_data, out_ready,
        output shakehands_next, out_data, out_valid
    );

    modport slave (
        output empty, fifo_data, out_ready,
        input  shakehands_next, out_data, out_valid
    );

endinterface

// File: rtl/peri_readout_arbiter_rr_pick.sv
// Round-robin priority pick, purely combinational.
//   req : request per column (a column requests while its FIFO is non-empty)
//   ptr : column with highest priority this round
//   any : at least one request present
//   idx : first requesting column searching ptr, ptr+1, ... modulo N_COL
module rr_priority_pick
    import peri_pkg::*;
(
    input  logic [N_COL-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    int c;

    // Scan from the farthest offset down to offset 0 so the nearest
    // requester after ptr is the one left in idx.
    always_comb begin
        any = |req;
        idx = '0;
        c   = 0;
        for (int k = N_COL - 1; k >= 0; k--) begin
            c = (int'(ptr) + k) % N_COL;
            if (req[IDX_W'(c)]) begin
                idx = IDX_W'(c);
            end
        end
    end

endmodule

// File: rtl/peri_readout_arbiter.sv
// Column-peripheral readout arbiter.
// Polls the column FIFOs round-robin, drains up to BURST words per grant
// and forwards each word tagged with its column index on a valid/ready stream.
//   clk_40MHz : clock, rising edge
//   rst       : synchronous active-high reset
//   en        : arbitration enable; low blocks any new grant
//   bus       : FIFO heads/empties, pop pulses and output stream (master modport)
//   busy      : FSM not in IDLE
//   word_cnt  : words accepted downstream, wraps
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no column granted; pick next non-empty column from ptr
// GRANT | pop pulse on sel this cycle; capture FIFO head into out_data
// HOLD  | out_valid high, waiting for out_ready; then continue or leave
module peri_readout_arbiter
    import peri_pkg::*;
#(
    parameter int BURST = BURST_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk_40MHz,
    input  logic                   rst,
    input  logic                   en,
    peri_readout_arbiter_if.master bus,
    output logic                   busy,
    output logic [CNT_W-1:0]       word_cnt
);

    localparam int BC_W = $clog2(BURST) + 1;

    arb_state_t        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  sel_q, sel_d;
    logic [BC_W-1:0]   burst_q, burst_d;
    logic [N_COL-1:0]  shake_q, shake_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              pick_any;
    logic [IDX_W-1:0]  pick_idx;
    logic [DATA_W-1:0] col_word [N_COL];

    for (genvar g = 0; g < N_COL; g++) begin : g_col_word
        assign col_word[g] = bus.fifo_data[g*DATA_W +: DATA_W];
    end

    rr_priority_pick u_pick (
        .req (~bus.empty),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk_40MHz) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            burst_q     <= '0;
            shake_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            burst_q     <= burst_d;
            shake_q     <= shake_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        burst_d     = burst_q;
        shake_d     = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (en && pick_any) begin
                    sel_d   = pick_idx;
                    burst_d = '0;
                    shake_d = onehot(pick_idx);
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                // The source pops on this edge; its head is still on fifo_data.
                out_data_d  = {sel_q, col_word[sel_q]};
                out_valid_d = 1'b1;
                state_d     = ST_HOLD;
            end
            ST_HOLD: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + CNT_W'(1);
                    burst_d     = burst_q + BC_W'(1);
                    if ((int'(burst_q) + 1 < BURST) && !bus.empty[sel_q] && en) begin
                        shake_d = onehot(sel_q);
                        state_d = ST_GRANT;
                    end else begin
                        // Served column drops to lowest priority.
                        ptr_d   = (sel_q == IDX_W'(N_COL - 1)) ? '0 : sel_q + IDX_W'(1);
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.shakehands_next = shake_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_valid       = out_valid_q;
    assign busy                = busy_q;
    assign word_cnt            = cnt_q;

endmodule

// File: tb/tb_peri_readout_arbiter.sv
module tb_peri_readout_arbiter;
    import peri_pkg::*;

    logic                 clk_40MHz = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 busy;
    logic [CNT_W_DEF-1:0] word_cnt;

    peri_readout_arbiter_if bus ();

    peri_readout_arbiter #(.BURST(BURST_DEF), .CNT_W(CNT_W_DEF)) dut (
        .clk_40MHz (clk_40MHz),
        .rst       (rst),
        .en        (en),
        .bus       (bus),
        .busy      (busy),
        .word_cnt  (word_cnt)
    );

    always #12 clk_40MHz = ~clk_40MHz;

    int errors = 0;
    int checks = 0;

    // Column FIFO model contents, acceptance log and protocol monitor state.
    logic [DATA_W-1:0] src_q [N_COL][$];
    logic [DATA_W-1:0] mir   [N_COL][$];
    logic [OUT_W-1:0]  acc_q [$];
    int                acc_cyc [$];
    logic [OUT_W-1:0]  exp_q [$];
    logic [N_COL-1:0]  pend = '0;
    logic [N_COL-1:0]  mon_sh;
    int                cyc = 0;
    int                viol = 0;
    int                grant_cnt = 0;
    int                exp_cnt = 0;
    int                mptr = 0;

    // Sources and monitor, all at the falling edge.  A grant seen here pops
    // at the following rising edge, so the pop is applied one negedge later.
    always @(negedge clk_40MHz) begin
        for (int i = 0; i < N_COL; i++)
            if (pend[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        mon_sh = bus.shakehands_next;
        if (mon_sh != '0) begin
            grant_cnt++;
            if (!$onehot(mon_sh)) viol++;
            for (int i = 0; i < N_COL; i++)
                if (mon_sh[i] && src_q[i].size() == 0) viol++;
        end
        pend = mon_sh;
        if (!rst && bus.out_valid && bus.out_ready) begin
            acc_q.push_back(bus.out_data);
            acc_cyc.push_back(cyc);
        end
        cyc++;
        for (int i = 0; i < N_COL; i++) begin
            bus.empty[i] = (src_q[i].size() == 0);
            bus.fifo_data[i*DATA_W +: DATA_W] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_40MHz);
            #1;
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        exp_cnt = 0;
        mptr = 0;
    endtask

    task automatic push(input int c, input logic [DATA_W-1:0] w);
        src_q[c].push_back(w);
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int t = 0;
        while (acc_q.size() < n && t < budget) begin
            step(1);
            t++;
        end
        checks++;
        if (acc_q.size() < n) begin
            errors++;
            $display("FAIL %s: timeout, accepted %0d words, required %0d", name, acc_q.size(), n);
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        int t = 0;
        while (bus.out_valid !== 1'b1 && t < budget) begin
            step(1);
            t++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: timeout waiting out_valid, got %b required 1", name, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 1'b1;
        bus.out_ready = 1'b1;
        step(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            checks++;
            if (bus.shakehands_next !== '0 || bus.out_valid !== 1'b0 || busy !== 1'b0 ||
                word_cnt !== CNT_W_DEF'(0) || bus.out_data !== '0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: sh=%h valid=%b busy=%b cnt=%0d data=%h, required all zero",
                         i, bus.shakehands_next, bus.out_valid, busy, word_cnt, bus.out_data);
            end
        end
    endtask

    task automatic test_single_col_burst();
        logic [DATA_W-1:0] w [6];
        int base = acc_q.size();
        for (int k = 0; k < 6; k++) begin
            w[k] = DATA_W'($urandom);
            push(5, w[k]);
        end
        wait_acc(base + 6, 100, "burst_done");
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (acc_q[base+k] !== {IDX_W'(5), w[k]}) begin
                errors++;
                $display("FAIL burst_word%0d: got %h required %h", k, acc_q[base+k], {IDX_W'(5), w[k]});
            end
        end
        // Within a burst one word every 2 cycles; after 4 words a trip through IDLE adds one.
        for (int k = 1; k < 6; k++) begin
            checks++;
            if (acc_cyc[base+k] - acc_cyc[base+k-1] !== ((k == 4) ? 3 : 2)) begin
                errors++;
                $display("FAIL burst_gap%0d: got %0d cycles required %0d", k,
                         acc_cyc[base+k] - acc_cyc[base+k-1], (k == 4) ? 3 : 2);
            end
        end
        exp_cnt += 6;
        step(2);
        checks++;
        if (word_cnt !== CNT_W_DEF'(exp_cnt)) begin
            errors++;
            $display("FAIL burst_cnt: got %0d required %0d", word_cnt, exp_cnt);
        end
    endtask

    task automatic test_rr_order();
        int cols [5] = '{0, 3, 7, 0, 3};
        logic [DATA_W-1:0] w [5];
        int base;
        apply_reset();
        base = acc_q.size();
        for (int k = 0; k < 5; k++) w[k] = DATA_W'($urandom);
        for (int k = 0; k < 3; k++) push(cols[k], w[k]);
        wait_acc(base + 3, 100, "rr_first");
        push(0, w[3]);
        push(3, w[4]);
        wait_acc(base + 5, 100, "rr_second");
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (acc_q[base+k] !== {IDX_W'(cols[k]), w[k]}) begin
                errors++;
                $display("FAIL rr_order%0d: got %h required %h", k, acc_q[base+k], {IDX_W'(cols[k]), w[k]});
            end
        end
        exp_cnt += 5;
        step(2);
        checks++;
        if (word_cnt !== CNT_W_DEF'(exp_cnt)) begin
            errors++;
            $display("FAIL rr_cnt: got %0d required %0d", word_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        int base = acc_q.size();
        int g0;
        bus.out_ready = 1'b0;
        push(2, 28'hABCDE12);
        push(2, 28'h1234567);
        wait_valid(50, "bp_valid");
        g0 = grant_cnt;
        for (int i = 0; i < 10; i++) begin
            step(1);
            checks++;
            if (bus.out_data !== {IDX_W'(2), 28'hABCDE12} || bus.out_valid !== 1'b1 ||
                bus.shakehands_next !== '0) begin
                errors++;
                $display("FAIL bp_hold%0d: data=%h valid=%b sh=%h, required data=%h valid=1 sh=0",
                         i, bus.out_data, bus.out_valid, bus.shakehands_next, {IDX_W'(2), 28'hABCDE12});
            end
        end
        checks++;
        if (grant_cnt !== g0) begin
            errors++;
            $display("FAIL bp_no_grant: got %0d grants during stall required 0", grant_cnt - g0);
        end
        bus.out_ready = 1'b1;
        wait_acc(base + 2, 50, "bp_release");
        checks++;
        if (acc_q[base] !== {IDX_W'(2), 28'hABCDE12} || acc_q[base+1] !== {IDX_W'(2), 28'h1234567}) begin
            errors++;
            $display("FAIL bp_words: got %h %h required %h %h", acc_q[base], acc_q[base+1],
                     {IDX_W'(2), 28'hABCDE12}, {IDX_W'(2), 28'h1234567});
        end
        exp_cnt += 2;
        step(2);
        checks++;
        if (word_cnt !== CNT_W_DEF'(exp_cnt)) begin
            errors++;
            $display("FAIL bp_cnt: got %0d required %0d", word_cnt, exp_cnt);
        end
    endtask

    task automatic test_en_drop();
        logic [DATA_W-1:0] w4 [5];
        logic [DATA_W-1:0] w6;
        logic [OUT_W-1:0]  expw [6];
        int base = acc_q.size();
        int g0;
        // ptr now sits at 3 (column 2 was served last).
        bus.out_ready = 1'b0;
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w4[k] = DATA_W'($urandom);
            push(4, w4[k]);
        end
        w6 = DATA_W'($urandom);
        push(6, w6);
        wait_valid(50, "en_word1");
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        wait_valid(50, "en_word2");
        en = 1'b0;
        bus.out_ready = 1'b1;
        g0 = grant_cnt;
        step(15);
        checks++;
        if (acc_q.size() !== base + 2 || grant_cnt !== g0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL en_low_idle: accepted=%0d grants=%0d busy=%b, required accepted=%0d grants=0 busy=0",
                     acc_q.size() - base, grant_cnt - g0, busy, 2);
        end
        en = 1'b1;
        wait_acc(base + 6, 100, "en_resume");
        expw = '{{IDX_W'(4), w4[0]}, {IDX_W'(4), w4[1]}, {IDX_W'(6), w6},
                 {IDX_W'(4), w4[2]}, {IDX_W'(4), w4[3]}, {IDX_W'(4), w4[4]}};
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (acc_q[base+k] !== expw[k]) begin
                errors++;
                $display("FAIL en_order%0d: got %h required %h", k, acc_q[base+k], expw[k]);
            end
        end
        exp_cnt += 6;
    endtask

    task automatic test_reset_mid();
        logic [DATA_W-1:0] x [3];
        logic [DATA_W-1:0] wz;
        logic [OUT_W-1:0]  expw [3];
        int base;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            x[k] = DATA_W'($urandom);
            push(5, x[k]);
        end
        wait_valid(50, "rm_valid");
        rst = 1'b1;
        step(1);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.shakehands_next !== '0 || word_cnt !== CNT_W_DEF'(0) || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_cleared: valid=%b sh=%h cnt=%0d busy=%b, required all zero",
                     bus.out_valid, bus.shakehands_next, word_cnt, busy);
        end
        wz = DATA_W'($urandom);
        push(0, wz);
        step(1);
        rst = 1'b0;
        exp_cnt = 0;
        mptr = 0;
        base = acc_q.size();
        bus.out_ready = 1'b1;
        wait_acc(base + 3, 100, "rm_restart");
        // x[0] was popped into the output register and lost to the reset.
        expw = '{{IDX_W'(0), wz}, {IDX_W'(5), x[1]}, {IDX_W'(5), x[2]}};
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (acc_q[base+k] !== expw[k]) begin
                errors++;
                $display("FAIL rm_order%0d: got %h required %h", k, acc_q[base+k], expw[k]);
            end
        end
        exp_cnt += 3;
        step(2);
        checks++;
        if (word_cnt !== CNT_W_DEF'(exp_cnt)) begin
            errors++;
            $display("FAIL rm_cnt: got %0d required %0d", word_cnt, exp_cnt);
        end
        mptr = 6;
    endtask

    // Reference: serve columns round-robin from mptr, up to BURST words per
    // visit, moving mptr past each column as it is left.
    task automatic model_expected();
        int remaining = 0;
        int c;
        exp_q.delete();
        for (int i = 0; i < N_COL; i++) remaining += mir[i].size();
        while (remaining > 0) begin
            c = -1;
            for (int k = 0; k < N_COL; k++) begin
                if (c < 0 && mir[(mptr + k) % N_COL].size() > 0) c = (mptr + k) % N_COL;
            end
            for (int b = 0; b < BURST_DEF; b++) begin
                if (mir[c].size() > 0) begin
                    exp_q.push_back({IDX_W'(c), mir[c].pop_front()});
                    remaining--;
                end
            end
            mptr = (c + 1) % N_COL;
        end
    endtask

    task automatic test_random();
        int base;
        int t;
        apply_reset();
        for (int r = 0; r < 3; r++) begin
            en = 1'b0;
            for (int i = 0; i < N_COL; i++) begin
                int n = $urandom_range(0, 6);
                for (int k = 0; k < n; k++) begin
                    logic [DATA_W-1:0] w = DATA_W'($urandom);
                    push(i, w);
                    mir[i].push_back(w);
                end
            end
            model_expected();
            base = acc_q.size();
            step(1);
            en = 1'b1;
            t = 0;
            while (acc_q.size() < base + exp_q.size() && t < 3000) begin
                bus.out_ready = 1'($urandom_range(0, 1));
                step(1);
                t++;
            end
            bus.out_ready = 1'b1;
            checks++;
            if (acc_q.size() < base + exp_q.size()) begin
                errors++;
                $display("FAIL rnd%0d_timeout: accepted %0d required %0d", r, acc_q.size() - base, exp_q.size());
            end
            for (int k = 0; k < exp_q.size(); k++) begin
                checks++;
                if (acc_q[base+k] !== exp_q[k]) begin
                    errors++;
                    $display("FAIL rnd%0d_word%0d: got %h required %h", r, k, acc_q[base+k], exp_q[k]);
                end
            end
            exp_cnt += exp_q.size();
            step(3);
            checks++;
            if (word_cnt !== CNT_W_DEF'(exp_cnt)) begin
                errors++;
                $display("FAIL rnd%0d_cnt: got %0d required %0d", r, word_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_invariants();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL grant_invariant: got %0d multi-hot or empty-column grants required 0", viol);
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_single_col_burst();
        test_rr_order();
        test_backpressure();
        test_en_drop();
        test_reset_mid();
        test_random();
        test_invariants();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/peri_readout_arbiter.md
Name: peri_readout_arbiter

Overview:
- Downstream consumer of the column peripheral nodes: polls N_COL column-peripheral FIFOs (each exposing `empty` and a 28-bit `fifo_data`) and grants one at a time via a one-hot `shakehands_next`.
- Drains up to BURST words per grant, tags each word with its column index and presents it on a single valid/ready stream toward the chip readout serializer.
- Round-robin fairness across columns; no column can starve another.

Parameters:
- N_COL, 8, number of column-peripheral sources arbitrated.
- IDX_W, 3, column index width; must satisfy 2**IDX_W >= N_COL.
- DATA_W, 28, width of one source fifo_data word.
- BURST, 4, maximum words drained from one column per grant (>=1).
- CNT_W, 16, width of the forwarded-word counter.

Ports:
- clk_40MHz  input  1  single clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  arbitration enable; low prevents starting a new grant.
- empty  input  N_COL  per-column FIFO empty; bit i belongs to column i.
- fifo_data  input  N_COL*DATA_W  packed source words; column i at [i*DATA_W +: DATA_W]. Sources are first-word-fall-through: the word is valid whenever empty[i]=0.
- shakehands_next  output  N_COL  one-hot grant/pop pulse; the source pops on the edge where its bit is 1.
- out_data  output  IDX_W+DATA_W  {col_idx, word}.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts when out_valid&out_ready at an edge.
- busy  output  1  high in any state other than IDLE.
- word_cnt  output  CNT_W  number of words accepted downstream; wraps modulo 2**CNT_W.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ptr=0, sel=0, burst_cnt=0. Outputs: shakehands_next=0, out_data=0, out_valid=0, busy=0, word_cnt=0. A word popped but not yet accepted is discarded.
- All outputs are registered.
- FSM states: IDLE, GRANT, HOLD.
- IDLE, selection:
  - If en=1 and any bit of ~empty is set, pick sel as the first non-empty column searching ptr, ptr+1, … modulo N_COL.
  - burst_cnt<=0; shakehands_next<=onehot(sel); go to GRANT.
  - Otherwise stay in IDLE.
- GRANT, exactly 1 cycle:
  - shakehands_next[sel]=1. At this edge: out_data<={sel, fifo_data[sel]}, out_valid<=1, shakehands_next<=0, go to HOLD.
  - Only the arbiter pops the sources, so an empty bit sampled low in the previous cycle is still valid.
- HOLD, on out_valid&out_ready:
  - out_valid<=0; word_cnt<=word_cnt+1; burst_cnt<=burst_cnt+1.
  - If burst_cnt+1<BURST and empty[sel]=0 and en=1: shakehands_next<=onehot(sel), go to GRANT.
  - Otherwise: ptr<=(sel==N_COL-1)?0:sel+1, go to IDLE.
  - If out_ready=0, hold out_data and out_valid stable indefinitely; no pops occur.
- Latency: non-empty source in IDLE → grant pulse 1 cycle later → out_valid 2 cycles later.
- Throughput: one word per 2 cycles at most (GRANT+HOLD with out_ready=1 throughout).
- en falling mid-burst: the current word completes, then return to IDLE; no new grant is issued while en=0.
- ptr advances only on leaving a column, so the last-served column gets the lowest priority next time.
- Only the low log2 bits of ptr/sel are used; columns with index >= N_COL never exist.
- shakehands_next is never multi-hot and never asserted for an empty column.

Decomposition:
- Shared package peri_pkg: DATA_W=28, IDX_W, the FSM state encoding (IDLE/GRANT/HOLD), and a function onehot(idx).
- Natural sub-module: rr_priority_pick. Combinational; inputs req[N_COL] (=~empty) and ptr; outputs any and idx. Instantiated once.

Test Plan:
- After reset, all empty=1, en=1 for 20 cycles → shakehands_next stays 0, out_valid stays 0, busy stays 0, word_cnt=0.
- Only column 5 non-empty holding 6 words, BURST=4, out_ready=1 → 4 grant pulses on bit 5, out_data[30:28]=5, return to IDLE, then 2 more words; word_cnt=6; words in source order.
- Columns 0, 3, 7 each holding 1 word, ptr=0 → service order 0,3,7; then 0 refilled with 1 word and 3 refilled → order 0,3 (ptr wrapped from 7 to 0).
- out_ready held low 10 cycles with out_valid=1, data 28'hABCDE12 from column 2 → out_data stable for 10 cycles, no further shakehands_next pulses; released → accepted, word_cnt +1.
- en dropped during HOLD of the 2nd burst word with 3 more words pending → current word is accepted, FSM goes to IDLE, no grant while en=0; en=1 → next column served.
- rst asserted during HOLD → next cycle out_valid=0, shakehands_next=0, word_cnt=0, ptr=0; after release arbitration restarts from column 0.
